// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between instruction memory and decode.
// Entries hold {instr, pcplus4}. The head drives decode combinationally and reads
// as all-zero (a NOP) when the queue is empty. Flush and Reset empty the queue.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          FetchValid,
  input  logic [31:0]   FetchInstr,
  input  logic [31:0]   FetchPCPlus4,
  output logic          FetchReady,
  input  logic          Flush,
  input  logic          DecodeStall,
  output logic          DecodeValid,
  output logic [31:0]   Instr,
  output logic [31:0]   PCPlus4,
  output logic [15:0]   Imm,
  output logic [5:0]    Opcode,
  output logic [CW-1:0] Count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Handshake decode; ready ignores a same-cycle pop so a full queue always refuses.
  always_comb begin
    FetchReady  = !Reset && !Flush && (count_reg < CW'(DEPTH));
    DecodeValid = (count_reg != '0);
    push        = FetchValid && FetchReady;
    pop         = DecodeValid && !DecodeStall;
  end

  // Next-state for pointers and occupancy; Reset and Flush both empty the queue.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (Reset || Flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  // State register for pointers and occupancy.
  always_ff @(posedge Clk) begin
    rd_ptr_reg <= rd_ptr_next;
    wr_ptr_reg <= wr_ptr_next;
    count_reg  <= count_next;
  end

  // Entry storage; push already excludes Reset and Flush cycles.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {FetchInstr, FetchPCPlus4};
    end
  end

  // Head presentation; zeroed when empty so decode sees a NOP.
  always_comb begin
    head    = mem[rd_ptr_reg];
    Instr   = DecodeValid ? head[63:32] : 32'h0000_0000;
    PCPlus4 = DecodeValid ? head[31:0]  : 32'h0000_0000;
    Imm     = Instr[15:0];
    Opcode  = Instr[31:26];
    Count   = count_reg;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a queue-based reference
// model compared every cycle, plus literal expectations at key points.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          Clk;
  logic          Reset;
  logic          FetchValid;
  logic [31:0]   FetchInstr;
  logic [31:0]   FetchPCPlus4;
  logic          FetchReady;
  logic          Flush;
  logic          DecodeStall;
  logic          DecodeValid;
  logic [31:0]   Instr;
  logic [31:0]   PCPlus4;
  logic [15:0]   Imm;
  logic [5:0]    Opcode;
  logic [CW-1:0] Count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .FetchValid(FetchValid), .FetchInstr(FetchInstr),
    .FetchPCPlus4(FetchPCPlus4), .FetchReady(FetchReady), .Flush(Flush),
    .DecodeStall(DecodeStall), .DecodeValid(DecodeValid), .Instr(Instr),
    .PCPlus4(PCPlus4), .Imm(Imm), .Opcode(Opcode), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {instr, pcplus4}.
  logic [63:0] q[$];
  bit          started = 0;

  always @(posedge Clk) begin
    bit do_push, do_pop;
    started = 1;
    if (Reset || Flush) begin
      q.delete();
    end else begin
      do_push = FetchValid && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && !DecodeStall;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({FetchInstr, FetchPCPlus4});
    end
  end

  // Every-cycle comparison against the model, mid-cycle when inputs are stable.
  always @(negedge Clk) begin
    logic [31:0] e_instr, e_pc;
    logic        e_valid, e_ready;
    if (started) begin
      e_valid = (q.size() != 0);
      e_instr = e_valid ? q[0][63:32] : 32'h0;
      e_pc    = e_valid ? q[0][31:0]  : 32'h0;
      e_ready = !Reset && !Flush && (q.size() < DEPTH);
      check("model_count",  32'(Count),       32'(q.size()));
      check("model_valid",  32'(DecodeValid), 32'(e_valid));
      check("model_ready",  32'(FetchReady),  32'(e_ready));
      check("model_instr",  Instr,            e_instr);
      check("model_pc",     PCPlus4,          e_pc);
      check("model_imm",    32'(Imm),         32'(e_instr[15:0]));
      check("model_opcode", 32'(Opcode),      32'(e_instr[31:26]));
    end
  end

  // Apply one cycle of inputs just after the rising edge.
  task automatic drive(input logic rst, input logic fl, input logic fv,
                       input logic [31:0] ins, input logic [31:0] pc, input logic st);
    @(posedge Clk);
    #1;
    Reset = rst; Flush = fl; FetchValid = fv; FetchInstr = ins; FetchPCPlus4 = pc;
    DecodeStall = st;
    $display("txn t=%0t rst=%0b flush=%0b fv=%0b instr=%h pc=%h stall=%0b",
             $time, rst, fl, fv, ins, pc, st);
  endtask

  // Wait until mid-cycle so directed checks see settled outputs for this cycle.
  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'h2008000A; words[1] = 32'h3129FFFF;
    words[2] = 32'h8D0AFFFC; words[3] = 32'h00000020;
    Reset = 1'b1; Flush = 1'b0; FetchValid = 1'b1; FetchInstr = 32'hDEADBEEF;
    FetchPCPlus4 = 32'h0; DecodeStall = 1'b0;

    // Reset with fetch traffic: nothing accepted.
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'hDEADBEEF, 32'h0, 0);
    settle();
    check("rst_ready", 32'(FetchReady), 32'h0);
    check("rst_count", 32'(Count), 32'h0);
    check("rst_instr", Instr, 32'h0);

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, words[i], 32'h1004 + 32'(4 * i), 1);
      if (i == 0) begin
        settle();
        check("post_rst_ready", 32'(FetchReady), 32'h1);
      end
    end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    settle();
    check("full_count",  32'(Count), 32'h4);
    check("full_ready",  32'(FetchReady), 32'h0);
    check("full_instr",  Instr, 32'h2008000A);
    check("full_imm",    32'(Imm), 32'h000A);
    check("full_opcode", 32'(Opcode), 32'h08);
    check("full_pc",     PCPlus4, 32'h1004);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 0);
      settle();
      check("drain_instr", Instr, words[i]);
      check("drain_pc", PCPlus4, 32'h1004 + 32'(4 * i));
    end
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    settle();
    check("empty_valid", 32'(DecodeValid), 32'h0);
    check("empty_instr", Instr, 32'h0);
    check("empty_count", 32'(Count), 32'h0);

    // Streaming through the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 0);
      settle();
      if (i > 0) begin
        check("stream_instr", Instr, 32'h100 + 32'(i - 1));
        check("stream_count", 32'(Count), 32'h1);
      end
    end
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    settle();
    check("stream_last", Instr, 32'h109);

    // Full with simultaneous pop: push refused, re-presented next cycle.
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h200 + 32'(i), 32'h3000 + 32'(4 * i), 1);
    drive(0, 0, 1, 32'h300, 32'h4000, 0);
    settle();
    check("fullpop_ready", 32'(FetchReady), 32'h0);
    check("fullpop_count", 32'(Count), 32'h4);
    drive(0, 0, 1, 32'h300, 32'h4000, 0);
    settle();
    check("refill_count", 32'(Count), 32'h3);
    check("refill_ready", 32'(FetchReady), 32'h1);
    check("refill_head",  Instr, 32'h201);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    settle();
    check("accepted_count", 32'(Count), 32'h3);
    check("accepted_head",  Instr, 32'h202);

    // Flush mid-stream with push and pop requested.
    drive(0, 1, 1, 32'h400, 32'h5000, 0);
    settle();
    check("flush_ready", 32'(FetchReady), 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    settle();
    check("flush_count", 32'(Count), 32'h0);
    check("flush_valid", 32'(DecodeValid), 32'h0);
    check("flush_instr", Instr, 32'h0);

    // Flush while decode stalled.
    drive(0, 0, 1, 32'h500, 32'h6000, 1);
    drive(0, 1, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    settle();
    check("stallflush_count", 32'(Count), 32'h0);

    // Reset together with Flush and traffic.
    drive(0, 0, 1, 32'h600, 32'h7000, 1);
    drive(0, 0, 1, 32'h601, 32'h7004, 1);
    drive(1, 1, 1, 32'h602, 32'h7008, 0);
    settle();
    check("rstflush_ready", 32'(FetchReady), 32'h0);
    check("rstflush_count_before", 32'(Count), 32'h2);
    drive(0, 0, 1, 32'h700, 32'h8000, 0);
    settle();
    check("resume_count", 32'(Count), 32'h0);
    check("resume_ready", 32'(FetchReady), 32'h1);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    settle();
    check("resume_instr", Instr, 32'h700);
    check("resume_pc", PCPlus4, 32'h8000);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between instruction memory and the decode stage. Fetched words and their PC+4 enter at the tail under a valid/ready handshake. The oldest entry drives decode, including the 16-bit immediate and 6-bit opcode fields consumed by the sign/zero-extension logic. The queue decouples fetch from decode stalls and discards all buffered instructions on a taken branch/jump flush.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- CW, 3: count width; equals log2(DEPTH)+1.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- FetchValid  input  1  fetch presents a word this cycle.
- FetchInstr  input  32  fetched instruction.
- FetchPCPlus4  input  32  PC+4 of the fetched instruction.
- FetchReady  output  1  queue accepts a word this cycle.
- Flush  input  1  discard all entries (taken branch/jump).
- DecodeStall  input  1  decode cannot accept the head this cycle.
- DecodeValid  output  1  head entry is valid.
- Instr  output  32  head instruction.
- PCPlus4  output  32  head PC+4.
- Imm  output  16  Instr[15:0], to the extension unit input.
- Opcode  output  6  Instr[31:26], to the extension unit opcode select.
- Count  output  CW  number of valid entries, 0..DEPTH.

## Operation

- Storage is a circular buffer of DEPTH entries, each 64 bits ({instr, pcplus4}). The read pointer and write pointer are each log2(DEPTH) bits and wrap modulo DEPTH. Count is held in a register.
- FetchReady = !Reset && !Flush && (Count < DEPTH). It is combinational from the registered count, Reset and Flush only. It does not depend on a same-cycle pop (no full-pop bypass).
- Push = FetchValid && FetchReady. On a push, the entry is written at the write pointer and the write pointer increments.
- DecodeValid = (Count != 0).
- Pop = DecodeValid && !DecodeStall. On a pop, the read pointer increments.
- Count update:
  - Push only: Count + 1.
  - Pop only: Count − 1.
  - Push and pop together: Count unchanged.
- Instr/PCPlus4 show the entry at the read pointer when DecodeValid = 1. They are forced to 32'h00000000 when empty, so the decode stage sees a NOP.
- Imm and Opcode are slices of Instr. They are therefore 0 when empty.
- Flush (checked when Reset = 0):
  - Next edge sets Count = 0 and both pointers = 0.
  - Any push or pop in the same cycle has no effect.
  - A Flush arriving while DecodeStall = 1 still clears the queue.
- Reset has priority over Flush and has the same effect on state. Stored data contents are don't-care after Reset or Flush.
- Priority order: Reset > Flush > push/pop.

## Timing

- Reset values:
  - Count = 0, DecodeValid = 0.
  - Instr = PCPlus4 = 0, Imm = 0, Opcode = 0.
  - FetchReady = 0 while Reset is high; 1 in the first cycle after Reset deasserts.
- Latency: a word pushed at edge N appears on Instr with DecodeValid = 1 in the cycle after edge N. There is no empty-queue bypass.
- Throughput: one push and one pop per cycle sustained when 0 < Count < DEPTH.
- Full (Count = DEPTH): FetchReady = 0 even if a pop occurs in the same cycle. It returns to 1 the cycle after the pop edge.
- Empty: DecodeStall is ignored. Count never underflows and never exceeds DEPTH.
- Pointer wrap: after entry DEPTH−1, the next push writes entry 0. FIFO order is preserved across the wrap.
- A Flush that coincides with FetchValid drops that word. Fetch re-presents from the redirected PC.

## Test plan

- Reset then fill: with Reset high, drive FetchValid = 1 -> FetchReady = 0 and Count stays 0. After release, push 0x2008000A, 0x3129FFFF, 0x8D0AFFFC, 0x00000020 with DecodeStall = 1 -> Count = 4 and FetchReady = 0. Instr = 0x2008000A, Imm = 0x000A, Opcode = 6'b001000.
- Drain order: from full, set DecodeStall = 0 for 4 cycles -> Instr sequence 0x2008000A, 0x3129FFFF, 0x8D0AFFFC, 0x00000020, matching PCPlus4 values. Then DecodeValid = 0, Instr = 0, Count = 0.
- Streaming and wrap: push 10 words at one per cycle with no stall, values 0x100+i -> each word appears one cycle after its push, in order. Count stays ≤ 1 and pointers wrap with no loss.
- Full with simultaneous pop: Count = 4, FetchValid = 1, DecodeStall = 0 -> the push is refused (FetchReady = 0) and Count = 3 next cycle. The refused word is accepted the following cycle, giving Count = 3.
- Flush mid-stream: Count = 3, Flush = 1 with FetchValid = 1 and DecodeStall = 0 -> next cycle Count = 0, DecodeValid = 0, Instr = 0. Neither the flush-cycle push nor the pop takes effect.
- Reset during Flush and traffic: Reset = 1 together with Flush and FetchValid at Count = 2 -> Count = 0 and FetchReady = 0 during Reset. Normal operation resumes the first cycle after Reset deasserts.
